// File: rtl/lift_car_ctrl.sv
// Lift car controller: moves the car one level per MOVE_TICKS slowref ticks,
// stops at levels requested in the travel direction and clears the served lamp.
module lift_car_ctrl #(
  parameter int NLEVELS    = 4,
  parameter int MOVE_TICKS = 4,
  parameter int DOOR_TICKS = 8,
  localparam int LW        = (NLEVELS > 1) ? $clog2(NLEVELS) : 1
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               slowref,
  input  logic [NLEVELS-1:0] upreq,
  input  logic [NLEVELS-1:0] dnreq,
  output logic [NLEVELS-1:0] clrup,
  output logic [NLEVELS-1:0] clrdn,
  output logic [LW-1:0]      level,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_DOOR
  } state_t;

  localparam int MAXT = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS - 1);
  localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);
  localparam logic [LW-1:0] TOP_LEVEL = LW'(NLEVELS - 1);
  localparam logic [LW-1:0] BOT_LEVEL = '0;

  state_t          state_reg, state_next;
  logic [LW-1:0]   level_reg, level_next;
  logic            dir_reg, dir_next;
  logic            serve_reg, serve_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            moving_reg, door_reg;

  logic [NLEVELS-1:0] req;
  logic [NLEVELS-1:0] above_vec;
  logic [NLEVELS-1:0] below_vec;
  logic [LW-1:0]      nl;
  logic               stop;
  logic               fwd_req;
  logic               door_tick;

  assign req = upreq | dnreq;

  // above_vec[i] / below_vec[i]: any request strictly above / below level i
  generate
    for (genvar gi = 0; gi < NLEVELS; gi++) begin : g_scan
      if (gi == NLEVELS - 1) begin : g_top
        assign above_vec[gi] = 1'b0;
      end else begin : g_not_top
        assign above_vec[gi] = |req[NLEVELS-1:gi+1];
      end
      if (gi == 0) begin : g_bot
        assign below_vec[gi] = 1'b0;
      end else begin : g_not_bot
        assign below_vec[gi] = |req[gi-1:0];
      end
    end
  endgenerate

  assign nl = dir_reg ? (level_reg + LW'(1)) : (level_reg - LW'(1));

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    dir_next   = dir_reg;
    serve_next = serve_reg;
    cnt_next   = cnt_reg;
    stop       = 1'b0;
    fwd_req    = 1'b0;
    if (slowref) begin
      case (state_reg)
        ST_IDLE: begin
          cnt_next = '0;
          if (req[level_reg]) begin
            // Both lamps lit at this level: keep serving the current direction
            serve_next = (upreq[level_reg] && dnreq[level_reg]) ? dir_reg : upreq[level_reg];
            dir_next   = serve_next;
            state_next = ST_DOOR;
          end else if (above_vec[level_reg] && (dir_reg || !below_vec[level_reg])) begin
            dir_next   = 1'b1;
            state_next = ST_MOVE;
          end else if (below_vec[level_reg]) begin
            dir_next   = 1'b0;
            state_next = ST_MOVE;
          end
        end
        ST_MOVE: begin
          if (cnt_reg == MOVE_LAST) begin
            level_next = nl;
            cnt_next   = '0;
            fwd_req    = dir_reg ? upreq[nl] : dnreq[nl];
            if (dir_reg) begin
              stop = fwd_req || (nl == TOP_LEVEL) || !above_vec[nl];
            end else begin
              stop = fwd_req || (nl == BOT_LEVEL) || !below_vec[nl];
            end
            if (stop) begin
              state_next = ST_DOOR;
              // No lamp in the travel direction here: turn round and serve the other one
              if (fwd_req) begin
                serve_next = dir_reg;
              end else begin
                serve_next = !dir_reg;
                dir_next   = !dir_reg;
              end
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        ST_DOOR: begin
          if (cnt_reg == DOOR_LAST) begin
            cnt_next   = '0;
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_reg  <= ST_IDLE;
      level_reg  <= '0;
      dir_reg    <= 1'b1;
      serve_reg  <= 1'b1;
      cnt_reg    <= '0;
      moving_reg <= 1'b0;
      door_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      level_reg  <= level_next;
      dir_reg    <= dir_next;
      serve_reg  <= serve_next;
      cnt_reg    <= cnt_next;
      moving_reg <= (state_next == ST_MOVE);
      door_reg   <= (state_next == ST_DOOR);
    end
  end

  // Clears only pulse on slowref cycles so the lamp latches see exactly one per tick
  assign door_tick = slowref & (state_reg == ST_DOOR);

  generate
    for (genvar gi = 0; gi < NLEVELS; gi++) begin : g_clr
      assign clrup[gi] = door_tick &  serve_reg & (level_reg == LW'(gi));
      assign clrdn[gi] = door_tick & ~serve_reg & (level_reg == LW'(gi));
    end
  endgenerate

  assign level     = level_reg;
  assign dir_up    = dir_reg;
  assign moving    = moving_reg;
  assign door_open = door_reg;

endmodule

// File: tb/tb_lift_car_ctrl.sv
// Bench for lift_car_ctrl: lamp latches plus a behavioural lift model, checked every clock.
module tb_lift_car_ctrl;
  localparam int NL = 4;
  localparam int MT = 4;
  localparam int DT = 8;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       slowref = 1'b0;
  logic [3:0] upreq = '0;
  logic [3:0] dnreq = '0;
  logic [3:0] clrup, clrdn;
  logic [1:0] level;
  logic       dir_up, moving, door_open;

  lift_car_ctrl #(.NLEVELS(NL), .MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
    .clk(clk), .resetb(resetb), .slowref(slowref),
    .upreq(upreq), .dnreq(dnreq), .clrup(clrup), .clrdn(clrdn),
    .level(level), .dir_up(dir_up), .moving(moving), .door_open(door_open)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [3:0] lamp_up = '0, lamp_dn = '0, press_up = '0, press_dn = '0;
  bit cur_rb, cur_sr;

  int m_st, m_lvl, m_cnt;
  bit m_dir, m_serve;

  logic [3:0]  exp_cu, exp_cd;
  logic [12:0] exp_vec, obs_vec;

  function automatic bit any_above(input int x, input logic [3:0] r);
    for (int j = x + 1; j < NL; j++) if (r[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input int x, input logic [3:0] r);
    for (int j = 0; j < x; j++) if (r[j]) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural lift: what happens on one clock edge given the lamps and controls
  task automatic model_tick(input bit rb, input bit sr, input logic [3:0] up, input logic [3:0] dn);
    logic [3:0] r;
    int nl;
    bit fwd, stop;
    r = up | dn;
    if (!rb) begin
      m_st = M_IDLE; m_lvl = 0; m_dir = 1; m_serve = 1; m_cnt = 0;
    end else if (sr) begin
      if (m_st == M_IDLE) begin
        if (r[m_lvl]) begin
          m_serve = (up[m_lvl] && dn[m_lvl]) ? m_dir : up[m_lvl];
          m_dir = m_serve; m_st = M_DOOR; m_cnt = 0;
        end else if (any_above(m_lvl, r) && (m_dir || !any_below(m_lvl, r))) begin
          m_dir = 1; m_st = M_MOVE; m_cnt = 0;
        end else if (any_below(m_lvl, r)) begin
          m_dir = 0; m_st = M_MOVE; m_cnt = 0;
        end
      end else if (m_st == M_MOVE) begin
        if (m_cnt == MT - 1) begin
          nl = m_dir ? m_lvl + 1 : m_lvl - 1;
          m_lvl = nl; m_cnt = 0;
          fwd = m_dir ? up[nl] : dn[nl];
          stop = m_dir ? (fwd || nl == NL - 1 || !any_above(nl, r))
                       : (fwd || nl == 0 || !any_below(nl, r));
          if (stop) begin
            m_st = M_DOOR;
            if (fwd) m_serve = m_dir;
            else begin m_serve = !m_dir; m_dir = !m_dir; end
          end
        end else m_cnt++;
      end else begin
        if (m_cnt == DT - 1) begin m_st = M_IDLE; m_cnt = 0; end
        else m_cnt++;
      end
    end
  endtask

  task automatic drive(input bit rb);
    @(negedge clk);
    cur_sr = (cyc % 4 == 0);
    cur_rb = rb;
    slowref = cur_sr; resetb = rb; upreq = lamp_up; dnreq = lamp_dn;
    #1;
    exp_cu = (cur_sr && m_st == M_DOOR && m_serve)  ? (4'b0001 << m_lvl) : 4'b0000;
    exp_cd = (cur_sr && m_st == M_DOOR && !m_serve) ? (4'b0001 << m_lvl) : 4'b0000;
    exp_vec = {2'(m_lvl), m_dir, (m_st == M_MOVE), (m_st == M_DOOR), exp_cu, exp_cd};
    obs_vec = {level, dir_up, moving, door_open, clrup, clrdn};
  endtask

  task automatic commit();
    model_tick(cur_rb, cur_sr, lamp_up, lamp_dn);
    lamp_up = (lamp_up & ~exp_cu) | press_up;
    lamp_dn = (lamp_dn & ~exp_cd) | press_dn;
    press_up = '0; press_dn = '0;
    cyc++;
  endtask

  task automatic apply_reset();
    drive(1'b0);
    commit();
    lamp_up = '0; lamp_dn = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 200; k++) begin
      drive(1'b1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      commit();
    end
    drive(1'b1);
    total++;
    if (obs_vec !== {2'd0, 1'b1, 1'b0, 1'b0, 4'b0, 4'b0}) begin bad++; $display("FAIL reset_state got=%h want=%h", obs_vec, {2'd0, 1'b1, 1'b0, 1'b0, 4'b0, 4'b0}); end
    commit();
  endtask

  task automatic test_single_up();
    int n_clr = 0;
    apply_reset();
    lamp_up[2] = 1'b1;
    for (int k = 0; k < 120; k++) begin
      drive(1'b1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL single_up cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      if (clrup[2]) n_clr++;
      commit();
    end
    total++;
    if (n_clr !== DT) begin bad++; $display("FAIL single_up_clr_count got=%0d want=%0d", n_clr, DT); end
    total++;
    if (obs_vec !== {2'd2, 1'b1, 1'b0, 1'b0, 4'b0, 4'b0}) begin bad++; $display("FAIL single_up_final got=%h want=%h", obs_vec, {2'd2, 1'b1, 1'b0, 1'b0, 4'b0, 4'b0}); end
  endtask

  task automatic test_reverse();
    int first_up3 = -1, first_dn1 = -1;
    apply_reset();
    lamp_dn[1] = 1'b1; lamp_up[3] = 1'b1;
    for (int k = 0; k < 280; k++) begin
      drive(1'b1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL reverse cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      if (clrup[3] && first_up3 < 0) first_up3 = k;
      if (clrdn[1] && first_dn1 < 0) first_dn1 = k;
      commit();
    end
    total++;
    if (first_up3 < 0 || first_dn1 <= first_up3) begin bad++; $display("FAIL reverse_order got up3=%0d dn1=%0d want 0<=up3<dn1", first_up3, first_dn1); end
    total++;
    if ({lamp_up, lamp_dn} !== 8'h00) begin bad++; $display("FAIL reverse_lamps got=%h want=00", {lamp_up, lamp_dn}); end
    total++;
    if (obs_vec !== {2'd1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0}) begin bad++; $display("FAIL reverse_final got=%h want=%h", obs_vec, {2'd1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0}); end
  endtask

  task automatic test_same_level();
    int first_u = -1, first_d = -1;
    apply_reset();
    lamp_up[2] = 1'b1;
    for (int k = 0; k < 120; k++) begin
      drive(1'b1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL same_level_setup cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      commit();
    end
    lamp_up[2] = 1'b1; lamp_dn[2] = 1'b1;
    for (int k = 0; k < 160; k++) begin
      drive(1'b1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL same_level cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      total++;
      if ((clrup & clrdn) !== 4'b0) begin bad++; $display("FAIL same_level_both cyc=%0d got up=%b dn=%b want disjoint", cyc, clrup, clrdn); end
      if (clrup[2] && first_u < 0) first_u = k;
      if (clrdn[2] && first_d < 0) first_d = k;
      commit();
    end
    total++;
    if (first_u < 0 || first_d <= first_u) begin bad++; $display("FAIL same_level_order got up=%0d dn=%0d want 0<=up<dn", first_u, first_d); end
    total++;
    if (obs_vec !== {2'd2, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0}) begin bad++; $display("FAIL same_level_final got=%h want=%h", obs_vec, {2'd2, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0}); end
  endtask

  task automatic test_top_down();
    int n_dn = 0, n_up = 0;
    bit seen_door = 0;
    apply_reset();
    lamp_dn[3] = 1'b1;
    for (int k = 0; k < 160; k++) begin
      drive(1'b1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL top_down cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      if (door_open && !seen_door) begin
        seen_door = 1;
        total++;
        if ({level, dir_up} !== {2'd3, 1'b0}) begin bad++; $display("FAIL top_down_arrival got lvl=%0d dir=%b want lvl=3 dir=0", level, dir_up); end
      end
      if (clrdn[3]) n_dn++;
      if (clrup != 4'b0) n_up++;
      commit();
    end
    total++;
    if ({n_dn, n_up} !== {DT, 0}) begin bad++; $display("FAIL top_down_clears got dn3=%0d up=%0d want dn3=%0d up=0", n_dn, n_up, DT); end
  endtask

  task automatic test_mid_move_reset();
    bit found = 0;
    int n_clr = 0;
    apply_reset();
    lamp_up[3] = 1'b1;
    for (int k = 0; k < 200 && !found; k++) begin
      drive(1'b1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL mid_reset_pre cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      commit();
      if (m_st == M_MOVE && m_lvl == 1 && m_cnt == 2) found = 1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL mid_reset_reach got=timeout want=MOVE lvl1 cnt2"); end
    drive(1'b0);
    commit();
    drive(1'b1);
    total++;
    if (obs_vec !== {2'd0, 1'b1, 1'b0, 1'b0, 4'b0, 4'b0}) begin bad++; $display("FAIL mid_reset_state got=%h want=%h", obs_vec, {2'd0, 1'b1, 1'b0, 1'b0, 4'b0, 4'b0}); end
    commit();
    for (int k = 0; k < 160; k++) begin
      drive(1'b1);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL mid_reset_resume cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      if (clrup[3]) n_clr++;
      commit();
    end
    total++;
    if (n_clr !== DT) begin bad++; $display("FAIL mid_reset_clr_count got=%0d want=%0d", n_clr, DT); end
  endtask

  task automatic test_random();
    bit rb;
    apply_reset();
    for (int k = 0; k < 2000; k++) begin
      rb = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < NL; i++) begin
        if ($urandom_range(0, 47) == 0) press_up[i] = 1'b1;
        if ($urandom_range(0, 47) == 0) press_dn[i] = 1'b1;
      end
      drive(rb);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      commit();
    end
  endtask

  initial begin
    m_st = M_IDLE; m_lvl = 0; m_dir = 1; m_serve = 1; m_cnt = 0;
    test_reset();
    test_single_up();
    test_reverse();
    test_same_level();
    test_top_down();
    test_mid_move_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
